// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = 2;
  localparam int COL_W    = 2;
  localparam int KEY_W    = 5;

  localparam logic [KEY_W-1:0] KEY_NONE = 5'd31;
  localparam logic [KEY_W-1:0] KEY_PWRB = 5'd10;
  localparam logic [KEY_W-1:0] KEY_STB  = 5'd13;
  localparam logic [KEY_W-1:0] KEY_NO   = 5'd14;
  localparam logic [KEY_W-1:0] KEY_YES  = 5'd15;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Index of the lowest active-low row; the lowest row wins when several are low.
  function automatic logic [ROW_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] r_n);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r_n[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider producing a one-cycle tick every SCAN_DIV clocks
module scan_tick_gen #(
  parameter int SCAN_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..SCAN_DIV-1 and wrap; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and level key event; KEYPAD_STROBE_EN adds key_strobe
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 27000,
  parameter int DEB_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic                keypad_pressed,
  output logic [KEY_W-1:0]    key,
  output logic                key_strobe
);

  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic                tick;
  logic [NUM_ROWS-1:0] rows_m, rows_s;
  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NUM_COLS-1:0] cols_n_q, cols_n_d;
  logic [NUM_ROWS-1:0] cand_rows_q, cand_rows_d;
  logic [KEY_W-1:0]    cand_code_q, cand_code_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic                pressed_q, pressed_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                cand_row_high;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs; idles high like the pull-ups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_m <= '1;
      rows_s <= '1;
    end else begin
      rows_m <= rows_n;
      rows_s <= rows_m;
    end
  end

  assign cand_row_high = rows_s[cand_code_q[3:2]];

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= '0;
      cols_n_q    <= 4'b1110;
      cand_rows_q <= '1;
      cand_code_q <= KEY_NONE;
      deb_q       <= '0;
      pressed_q   <= 1'b0;
      key_q       <= KEY_NONE;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cols_n_q    <= cols_n_d;
      cand_rows_q <= cand_rows_d;
      cand_code_q <= cand_code_d;
      deb_q       <= deb_d;
      pressed_q   <= pressed_d;
      key_q       <= key_d;
    end
  end

  // Next-state logic; everything moves only on a scan tick.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_rows_d = cand_rows_q;
    cand_code_d = cand_code_q;
    deb_d       = deb_q;
    pressed_d   = pressed_q;
    key_d       = key_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rows_s == 4'hF) begin
            col_d = col_q + COL_W'(1);
          end else begin
            cand_rows_d = rows_s;
            cand_code_d = {1'b0, lowest_row(rows_s), col_q};
            deb_d       = '0;
            state_d     = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (rows_s == cand_rows_q) begin
            if (deb_q == DEB_LAST) begin
              state_d   = PRESSED;
              pressed_d = 1'b1;
              key_d     = cand_code_q;
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (cand_row_high) begin
            deb_d   = '0;
            state_d = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (cand_row_high) begin
            if (deb_q == DEB_LAST) begin
              state_d   = SCAN;
              pressed_d = 1'b0;
              key_d     = KEY_NONE;
              col_d     = col_q + COL_W'(1);
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    cols_n_d = ~(4'b0001 << col_d);
  end

  assign cols_n         = cols_n_q;
  assign keypad_pressed = pressed_q;
  assign key            = key_q;

`ifdef KEYPAD_STROBE_EN
  logic strobe_q;

  // Pulse in the same cycle keypad_pressed rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= pressed_d & ~pressed_q;
    end
  end

  assign key_strobe = strobe_q;
`else
  assign key_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic       keypad_pressed;
  logic [4:0] key;
  logic       key_strobe;

  logic [15:0] held;
  int          e;
  int          checks;
  int          errors;

`ifdef KEYPAD_STROBE_EN
  localparam logic STB_EXP = 1'b1;
`else
  localparam logic STB_EXP = 1'b0;
`endif

  keypad_scanner #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .rows_n         (rows_n),
    .cols_n         (cols_n),
    .keypad_pressed (keypad_pressed),
    .key            (key),
    .key_strobe     (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
  endtask

  task automatic hold_until(input int n, input logic p, input logic [4:0] k, input string tag);
    while (e < n) begin
      next_edge();
      chk({tag, "_pressed"}, p, p);
      chk({tag, "_pressed"}, keypad_pressed, p);
      chk({tag, "_key"}, key, k);
      chk({tag, "_strobe"}, key_strobe, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cols"}, cols_n, 4'b1110);
    chk({tag, "_pressed"}, keypad_pressed, 1'b0);
    chk({tag, "_key"}, key, 5'd31);
    chk({tag, "_strobe"}, key_strobe, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    held   = '0;
    e      = 0;
    rst    = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    // Idle scanning: cold column rotates every 4 clocks
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [3:0] exp_cols;
      next_edge();
      exp_cols = ~(4'b0001 << ((e / 4) % 4));
      chk("idle_cols", cols_n, exp_cols);
      chk("idle_pressed", keypad_pressed, 1'b0);
      chk("idle_key", key, 5'd31);
    end

    // STB press, hold, clean release
    held = '0;
    held[13] = 1'b1;
    do_reset();
    hold_until(19, 1'b0, 5'd31, "stb_wait");
    next_edge();
    chk("stb_accept_pressed", keypad_pressed, 1'b1);
    chk("stb_accept_key", key, 5'd13);
    chk("stb_accept_strobe", key_strobe, STB_EXP);
    chk("stb_accept_cols", cols_n, 4'b1101);
    hold_until(40, 1'b1, 5'd13, "stb_hold");
    held[13] = 1'b0;
    hold_until(55, 1'b1, 5'd13, "stb_rel_deb");
    next_edge();
    chk("stb_release_pressed", keypad_pressed, 1'b0);
    chk("stb_release_key", key, 5'd31);
    chk("stb_release_cols", cols_n, 4'b1011);
    hold_until(64, 1'b0, 5'd31, "stb_after");

    // Release glitch of one tick keeps the key held
    held = '0;
    held[13] = 1'b1;
    do_reset();
    hold_until(19, 1'b0, 5'd31, "gl_wait");
    next_edge();
    chk("gl_accept_pressed", keypad_pressed, 1'b1);
    chk("gl_accept_key", key, 5'd13);
    hold_until(40, 1'b1, 5'd13, "gl_hold");
    held[13] = 1'b0;
    hold_until(44, 1'b1, 5'd13, "gl_up");
    held[13] = 1'b1;
    hold_until(72, 1'b1, 5'd13, "gl_repress");
    chk("gl_cols", cols_n, 4'b1101);

    // One-tick bounce on row2/col3
    held = '0;
    held[11] = 1'b1;
    do_reset();
    hold_until(16, 1'b0, 5'd31, "bn_wait");
    chk("bn_cols_held", cols_n, 4'b0111);
    held[11] = 1'b0;
    hold_until(20, 1'b0, 5'd31, "bn_abort");
    chk("bn_cols_no_adv", cols_n, 4'b0111);
    hold_until(24, 1'b0, 5'd31, "bn_resume");
    chk("bn_cols_resume", cols_n, 4'b1110);
    hold_until(60, 1'b0, 5'd31, "bn_idle");

    // Rows 2 and 3 on col2: lower row wins (PWRB)
    held = '0;
    held[10] = 1'b1;
    held[14] = 1'b1;
    do_reset();
    hold_until(23, 1'b0, 5'd31, "pw_wait");
    next_edge();
    chk("pw_accept_pressed", keypad_pressed, 1'b1);
    chk("pw_accept_key", key, 5'd10);
    chk("pw_accept_strobe", key_strobe, STB_EXP);
    hold_until(30, 1'b1, 5'd10, "pw_hold");

    // Asynchronous reset while PRESSED, then re-detect from scratch
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    hold_until(23, 1'b0, 5'd31, "re_wait");
    next_edge();
    chk("re_accept_pressed", keypad_pressed, 1'b1);
    chk("re_accept_key", key, 5'd10);
    chk("re_accept_strobe", key_strobe, STB_EXP);
    hold_until(32, 1'b1, 5'd10, "re_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
